// File: rtl/route_buffer_32b.sv
// route_buffer_32b: two-entry elastic buffer placed after a CGRA routing mux.
// In buffered mode words pass through a 2-deep FIFO with one cycle of latency.
// When cfg_bypass is set and the FIFO is empty, the input is wired straight to
// the output with the handshake passed through combinationally.
// The presented head word is held in its own register so that out stays at the
// last word shown when the FIFO runs empty, instead of showing a stale slot.
module route_buffer_32b #(
    parameter int size  = 32,
    parameter int DEPTH = 2
) (
    input  logic            CGRA_Clock,
    input  logic            CGRA_Reset_n,
    input  logic            CGRA_Enable,
    input  logic            cfg_bypass,
    input  logic [size-1:0] in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [size-1:0] out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      count
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [size-1:0] mem_r      [2];
    logic [size-1:0] mem_next_s [2];
    logic            wr_ptr_r;
    logic            wr_ptr_next_s;
    logic            rd_ptr_r;
    logic            rd_ptr_next_s;
    logic [1:0]      count_r;
    logic [1:0]      count_next_s;
    logic [size-1:0] head_r;
    logic [size-1:0] head_next_s;

    logic            bypass_active_s;
    logic            push_s;
    logic            pop_s;
    logic            buf_in_ready_s;
    logic            buf_out_valid_s;

    // Handshake: buffered-mode flags and the bypass pass-through selection.
    always_comb begin
        bypass_active_s = cfg_bypass && (count_r == 2'd0);
        buf_in_ready_s  = CGRA_Enable && (count_r != FULL_COUNT);
        buf_out_valid_s = (count_r != 2'd0);
        if (bypass_active_s) begin
            in_ready  = out_ready && CGRA_Enable;
            out_valid = in_valid && CGRA_Enable;
            out       = in;
        end else begin
            in_ready  = buf_in_ready_s;
            out_valid = buf_out_valid_s;
            out       = head_r;
        end
        push_s = in_valid && buf_in_ready_s && CGRA_Enable && !bypass_active_s;
        pop_s  = buf_out_valid_s && out_ready && CGRA_Enable && !bypass_active_s;
        count  = count_r;
    end

    // Next-state: storage write, pointer advance, occupancy and next head word.
    always_comb begin
        mem_next_s    = mem_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        head_next_s   = head_r;

        if (push_s) begin
            mem_next_s[wr_ptr_r] = in;
            wr_ptr_next_s        = ~wr_ptr_r;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = ~rd_ptr_r;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase

        // An empty buffer keeps showing the last head word.
        if (count_next_s != 2'd0) begin
            head_next_s = mem_next_s[rd_ptr_next_s];
        end else begin
            head_next_s = head_r;
        end
    end

    // State registers; reset clears storage so out reads 0 after reset.
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
        if (!CGRA_Reset_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            head_r   <= '0;
        end else begin
            mem_r[0] <= mem_next_s[0];
            mem_r[1] <= mem_next_s[1];
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
        end
    end

endmodule

// File: tb/tb_route_buffer_32b.sv
// Testbench for route_buffer_32b: table-driven directed vectors, hand-written
// stall and reset sequences, and randomized traffic against a queue model.
module tb_route_buffer_32b;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cfg;
    logic [31:0] din;
    logic        iv;
    logic        ir;
    logic [31:0] dout;
    logic        ov;
    logic        ordy;
    logic [1:0]  cnt;

    int n_cmp;
    int n_err;

    // Reference model: a plain queue of words plus the last word shown.
    logic [31:0] q[$];
    logic [31:0] last_out;

    route_buffer_32b #(.size(32), .DEPTH(2)) dut (
        .CGRA_Clock   (clk),
        .CGRA_Reset_n (rst_n),
        .CGRA_Enable  (en),
        .cfg_bypass   (cfg),
        .in           (din),
        .in_valid     (iv),
        .in_ready     (ir),
        .out          (dout),
        .out_valid    (ov),
        .out_ready    (ordy),
        .count        (cnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        cfg;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic [1:0]  e_cnt;
        logic        e_ov;
        logic [31:0] e_out;
        logic        e_ir;
    } vec_t;

    vec_t vt[15];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_bypass();
        return cfg && (q.size() == 0);
    endfunction

    function automatic logic m_ir();
        if (m_bypass()) return ordy && en;
        return en && (q.size() < 2);
    endfunction

    function automatic logic m_ov();
        if (m_bypass()) return iv && en;
        return q.size() != 0;
    endfunction

    function automatic logic [31:0] m_out();
        if (m_bypass()) return din;
        if (q.size() != 0) return q[0];
        return last_out;
    endfunction

    // Let inputs settle, then compare all outputs with the model.
    task automatic check_model(input string tag);
        #1;
        cmp({tag, ".count"},     32'(cnt), 32'(q.size()));
        cmp({tag, ".in_ready"},  32'(ir),  32'(m_ir()));
        cmp({tag, ".out_valid"}, 32'(ov),  32'(m_ov()));
        cmp({tag, ".out"},       dout,     m_out());
    endtask

    // Advance one clock edge and apply the handshake outcome to the model.
    task automatic tick();
        logic push;
        logic pop;
        push = iv && m_ir() && en && !m_bypass();
        pop  = m_ov() && ordy && en && !m_bypass();
        @(posedge clk);
        if (pop) last_out = q.pop_front();
        if (push) q.push_back(din);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        last_out = 32'h0;
        rst_n    = 1'b0;
        en       = 1'b1;
        cfg      = 1'b0;
        din      = 32'h0;
        iv       = 1'b0;
        ordy     = 1'b0;

        // Directed cycle table; expectations are for the cycle the inputs are applied.
        vt[0]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 32'h00000000, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 2'd1, 1'b1, 32'hDEADBEEF, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 2'd1, 1'b1, 32'hDEADBEEF, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 32'h00000001, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 32'h00000002, 1'b0, 2'd1, 1'b1, 32'h00000001, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 32'h00000003, 1'b0, 2'd2, 1'b1, 32'h00000001, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 32'h00000003, 1'b1, 2'd2, 1'b1, 32'h00000001, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 32'h00000003, 1'b1, 2'd1, 1'b1, 32'h00000002, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 2'd1, 1'b1, 32'h00000003, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 32'h0000000A, 1'b0, 2'd0, 1'b0, 32'h00000003, 1'b1};
        vt[10] = '{1'b0, 1'b1, 32'h0000000B, 1'b1, 2'd1, 1'b1, 32'h0000000A, 1'b1};
        vt[11] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 2'd1, 1'b1, 32'h0000000B, 1'b1};
        vt[12] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 2'd1, 1'b1, 32'h0000000B, 1'b1};
        vt[13] = '{1'b1, 1'b1, 32'h55AA55AA, 1'b1, 2'd0, 1'b1, 32'h55AA55AA, 1'b1};
        vt[14] = '{1'b1, 1'b0, 32'h12345678, 1'b0, 2'd0, 1'b0, 32'h12345678, 1'b0};

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.count",     32'(cnt), 32'd0);
        cmp("reset.out_valid", 32'(ov),  32'd0);
        cmp("reset.out",       dout,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            cfg  = vt[i].cfg;
            iv   = vt[i].iv;
            din  = vt[i].din;
            ordy = vt[i].ordy;
            #1;
            cmp($sformatf("vec%0d.count", i),     32'(cnt), 32'(vt[i].e_cnt));
            cmp($sformatf("vec%0d.out_valid", i), 32'(ov),  32'(vt[i].e_ov));
            cmp($sformatf("vec%0d.out", i),       dout,     vt[i].e_out);
            cmp($sformatf("vec%0d.in_ready", i),  32'(ir),  32'(vt[i].e_ir));
            tick();
        end

        // Stall with a full buffer: nothing moves for 3 cycles, then pops resume.
        cfg = 1'b0; ordy = 1'b0; iv = 1'b1;
        din = 32'hC0DE0001; check_model("fill0"); tick();
        din = 32'hC0DE0002; check_model("fill1"); tick();
        iv = 1'b0; en = 1'b0; ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_model($sformatf("stall%0d", i));
            cmp($sformatf("stall%0d.count_is_2", i), 32'(cnt), 32'd2);
            cmp($sformatf("stall%0d.in_ready_0", i), 32'(ir),  32'd0);
            tick();
        end
        en = 1'b1;
        check_model("resume0");
        cmp("resume0.out", dout, 32'hC0DE0001);
        tick();
        check_model("resume1");
        cmp("resume1.out", dout, 32'hC0DE0002);
        tick();
        check_model("resume2");

        // Reset between clock edges with a full buffer clears state immediately.
        ordy = 1'b0; iv = 1'b1;
        din = 32'hFEED0001; check_model("rfill0"); tick();
        din = 32'hFEED0002; check_model("rfill1"); tick();
        cmp("rfill.count", 32'(cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset.count",     32'(cnt), 32'd0);
        cmp("async_reset.out_valid", 32'(ov),  32'd0);
        cmp("async_reset.out",       dout,     32'h0);
        q.delete();
        last_out = 32'h0;
        @(posedge clk);
        #1;
        cmp("reset_hold.count", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        iv = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic, including bypass toggles while non-empty.
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(9, 0) != 0);
            iv   = $urandom_range(1, 0) == 1;
            ordy = $urandom_range(2, 0) != 0;
            din  = $urandom;
            if (($urandom_range(29, 0)) == 0) cfg = ~cfg;
            check_model($sformatf("rand%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/route_buffer_32b.md
ROUTE_BUFFER_32B -- requirements
Module: route_buffer_32b

Interface
REQ-001 Parameter: size, default 32, data width of every data port.
REQ-002 Parameter: DEPTH, fixed at 2; the entry count of the buffer. Other values are not supported.
REQ-003 CGRA_Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 CGRA_Reset_n  input  1  asynchronous, active-low reset.
REQ-005 CGRA_Enable  input  1  global stall; when 0, no internal state changes.
REQ-006 cfg_bypass  input  1  static configuration; 1 selects combinational pass-through when the buffer is empty.
REQ-007 in  input  size  data word from the upstream 7-to-1 routing mux output.
REQ-008 in_valid  input  1  upstream word valid.
REQ-009 in_ready  output  1  buffer can accept a word.
REQ-010 out  output  size  head-of-buffer data, or pass-through data.
REQ-011 out_valid  output  1  out holds a valid word.
REQ-012 out_ready  input  1  downstream accepts out this cycle.
REQ-013 count  output  2  current occupancy, range 0..2.

Function
REQ-014 The buffer SHALL be a 2-entry FIFO with a write pointer, a read pointer (1 bit each, wrapping 1->0) and a 2-bit occupancy counter.
REQ-015 Push SHALL occur when in_valid && in_ready && CGRA_Enable && !bypass_active; pop SHALL occur when out_valid && out_ready && CGRA_Enable && !bypass_active.
REQ-016 in_ready SHALL equal CGRA_Enable && (count != 2) in buffered mode; it SHALL NOT depend combinationally on out_ready.
REQ-017 out_valid SHALL equal (count != 0) in buffered mode; out SHALL equal the entry at the read pointer.
REQ-018 Latency in buffered mode SHALL be 1 cycle: a word pushed at edge N is presented on out after edge N.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; with count==1, the pushed word becomes the head after the popped one.
REQ-020 With count==2, in_ready SHALL be 0; a pop that cycle SHALL decrement count to 1, and in_ready SHALL rise the next cycle.
REQ-021 With count==0, out_valid SHALL be 0 and out SHALL be held at its last registered value, with no X and no pop.
REQ-022 bypass_active SHALL equal cfg_bypass && (count==0); while it is active: out=in, out_valid=in_valid && CGRA_Enable, in_ready=out_ready && CGRA_Enable, and the pointers and count SHALL NOT change.
REQ-023 If cfg_bypass rises while count!=0, the buffer SHALL drain in buffered mode first and enter bypass once count reaches 0.
REQ-024 CGRA_Enable==0 SHALL freeze the pointers, the count and the storage, and force in_ready to 0; out and out_valid SHALL reflect the frozen state in buffered mode.
REQ-025 Data ordering SHALL be strictly FIFO; no word is dropped or duplicated under any legal handshake sequence.

Reset
REQ-026 Assertion of CGRA_Reset_n=0 SHALL immediately, without a clock, set count=0, both pointers=0, out_valid=0, and storage=0 (so out=0 in buffered mode).
REQ-027 Reset asserted mid-transfer SHALL discard all stored words; a handshake in the same cycle SHALL have no effect.
REQ-028 Deassertion SHALL be synchronized by the integrator; the first push SHALL be accepted on the first rising edge after deassertion with CGRA_Enable=1.

Verification
REQ-029 After reset, push 0xDEADBEEF with out_ready=0 -> next cycle out=0xDEADBEEF, out_valid=1, count=1, in_ready=1.
REQ-030 Push 0x1 and 0x2 with out_ready=0 -> count=2, in_ready=0; an offered 0x3 is not accepted; raise out_ready -> outputs 0x1, 0x2, 0x3 in order.
REQ-031 With count=1 (head 0xA), push 0xB and pop in the same cycle -> count stays 1, out=0xB next cycle.
REQ-032 With cfg_bypass=1 and count=0, drive in=0x55AA55AA, in_valid=1, out_ready=1 -> same cycle out=0x55AA55AA, out_valid=1, in_ready=1, count=0.
REQ-033 With count=2, drive CGRA_Enable=0 for 3 cycles with out_ready=1 -> count remains 2 and in_ready=0; pops resume when CGRA_Enable returns to 1.
REQ-034 With count=2, assert CGRA_Reset_n=0 between clock edges -> count=0 and out_valid=0 immediately, before the next clock edge.
